// File: rtl/hex_field_pkg.sv
// Shared types and helpers for the hex_field debug overlay renderer.
package hex_field_pkg;

  localparam int GLYPH_W = 8;

  typedef logic [63:0] glyph_t;

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    // 'A' - 10 = 8'h37
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/hex_field_font.sv
// Combinational 8x8 font ROM for hex characters. Row 0 is the top byte and
// the MSB of each byte is the leftmost column; unknown codes render blank.
module hex_field_font
  import hex_field_pkg::*;
(
  input  logic [7:0] char_code,
  output glyph_t     glyph
);

  always_comb begin
    glyph = '0;
    case (char_code)
      8'h30:   glyph = 64'h3C666E7666663C00;
      8'h31:   glyph = 64'h1838181818187E00;
      8'h32:   glyph = 64'h3C66060C30607E00;
      8'h33:   glyph = 64'h3C66061C06663C00;
      8'h34:   glyph = 64'h0C1C3C6C7E0C0C00;
      8'h35:   glyph = 64'h7E607C0606663C00;
      8'h36:   glyph = 64'h3C607C6666663C00;
      8'h37:   glyph = 64'h7E060C1830303000;
      8'h38:   glyph = 64'h3C66663C66663C00;
      8'h39:   glyph = 64'h3C66663E060C3800;
      8'h41:   glyph = 64'h183C66667E666600;
      8'h42:   glyph = 64'h7C66667C66667C00;
      8'h43:   glyph = 64'h3C66606060663C00;
      8'h44:   glyph = 64'h786C6666666C7800;
      8'h45:   glyph = 64'h7E60607C60607E00;
      8'h46:   glyph = 64'h7E60607C60606000;
      default: glyph = '0;
    endcase
  end

endmodule

// File: rtl/hex_field.sv
// Renders a DIGITS-wide hex value as scaled 8x8 glyphs at (X0,Y0); new values
// take effect only at frame_start. Define HEX_FIELD_LZB_EN for leading-zero blanking.
module hex_field
  import hex_field_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int X0         = 0,
  parameter int Y0         = 0,
  parameter int XW         = 11,
  parameter int YW         = 10,
  parameter int SCALE_LOG2 = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  val_valid,
  output logic                  val_ready,
  input  logic [4*DIGITS-1:0]   val_data,
  input  logic                  px_valid,
  input  logic [XW-1:0]         px_x,
  input  logic [YW-1:0]         px_y,
  output logic                  pix_valid,
  output logic                  pixel
);

  localparam int CELL = GLYPH_W << SCALE_LOG2;
  localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW   = 4 * DIGITS;
  localparam int XB   = XW + 1;
  localparam int YB   = YW + 1;

  localparam logic [XB-1:0] X_LO = XB'(X0);
  localparam logic [XB-1:0] X_HI = XB'(X0 + DIGITS * CELL);
  localparam logic [YB-1:0] Y_LO = YB'(Y0);
  localparam logic [YB-1:0] Y_HI = YB'(Y0 + CELL);

  // Value path registers
  logic          init_reg;
  logic          pending_reg, pending_next;
  logic [VW-1:0] shadow_reg, shadow_next;
  logic [VW-1:0] display_reg, display_next;
  logic [DIGITS-1:0] blank_reg, blank_next;
  logic [DIGITS-1:0] lzb_mask;
  logic          accept;

  // Pixel pipeline registers
  logic          s1_valid_reg;
  logic          s1_in_field_reg, s1_in_field_next;
  logic [DW-1:0] s1_digit_reg, s1_digit_next;
  logic [2:0]    s1_col_reg, s1_col_next;
  logic [2:0]    s1_row_reg, s1_row_next;
  logic          pix_valid_reg;
  logic          pixel_reg, pixel_next;

  logic [XB-1:0] x_ext, dx;
  logic [YB-1:0] y_ext, dy;
  logic [3:0]    disp_nib [DIGITS];
  logic [3:0]    cur_nib;
  logic [7:0]    char_code;
  glyph_t        glyph;
  logic          glyph_bit;

  assign val_ready = init_reg && !pending_reg;
  assign accept    = val_valid && val_ready;

  // Digit 0 is the leftmost, most significant nibble.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign disp_nib[gi] = display_reg[4*(DIGITS-1-gi) +: 4];
    end
  endgenerate

`ifdef HEX_FIELD_LZB_EN
  // A digit is blank when it and every digit to its left are zero.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
      if (gi < DIGITS - 1) begin : g_lead
        assign lzb_mask[gi] = ~|shadow_reg[VW-1 -: 4*(gi+1)];
      end else begin : g_last
        assign lzb_mask[gi] = 1'b0;
      end
    end
  endgenerate
`else
  assign lzb_mask = '0;
`endif

  // Accept and frame transfer are mutually exclusive via pending_reg.
  always_comb begin
    shadow_next  = shadow_reg;
    pending_next = pending_reg;
    display_next = display_reg;
    blank_next   = blank_reg;
    if (frame_start && pending_reg) begin
      display_next = shadow_reg;
      blank_next   = lzb_mask;
      pending_next = 1'b0;
    end
    if (accept) begin
      shadow_next  = val_data;
      pending_next = 1'b1;
    end
  end

  // Stage 1: geometry on widened operands so nothing wraps.
  assign x_ext = {1'b0, px_x};
  assign y_ext = {1'b0, px_y};
  assign dx    = x_ext - X_LO;
  assign dy    = y_ext - Y_LO;

  always_comb begin
    s1_in_field_next = (x_ext >= X_LO) && (x_ext < X_HI) &&
                       (y_ext >= Y_LO) && (y_ext < Y_HI);
    s1_digit_next    = DW'(dx >> (3 + SCALE_LOG2));
    s1_col_next      = 3'(dx >> SCALE_LOG2);
    s1_row_next      = 3'(dy >> SCALE_LOG2);
  end

  // Stage 2: glyph lookup from the stage-1 registers.
  assign cur_nib   = disp_nib[s1_digit_reg];
  assign char_code = nib2ascii(cur_nib);

  hex_field_font u_font (
    .char_code (char_code),
    .glyph     (glyph)
  );

  assign glyph_bit  = glyph[6'd63 - {s1_row_reg, s1_col_reg}];
  assign pixel_next = s1_valid_reg && s1_in_field_reg &&
                      !blank_reg[s1_digit_reg] && glyph_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_reg        <= 1'b0;
      pending_reg     <= 1'b0;
      shadow_reg      <= '0;
      display_reg     <= '0;
      blank_reg       <= '0;
      s1_valid_reg    <= 1'b0;
      s1_in_field_reg <= 1'b0;
      s1_digit_reg    <= '0;
      s1_col_reg      <= '0;
      s1_row_reg      <= '0;
      pix_valid_reg   <= 1'b0;
      pixel_reg       <= 1'b0;
    end else begin
      init_reg        <= 1'b1;
      pending_reg     <= pending_next;
      shadow_reg      <= shadow_next;
      display_reg     <= display_next;
      blank_reg       <= blank_next;
      s1_valid_reg    <= px_valid;
      s1_in_field_reg <= s1_in_field_next;
      s1_digit_reg    <= s1_digit_next;
      s1_col_reg      <= s1_col_next;
      s1_row_reg      <= s1_row_next;
      pix_valid_reg   <= s1_valid_reg;
      pixel_reg       <= pixel_next;
    end
  end

  assign pix_valid = pix_valid_reg;
  assign pixel     = pixel_reg;

endmodule
